// File: rtl/vx_sched_wctl_checker_pkg.sv
// Shared types for the scheduler warp-control checker: error codes, FSM states
// and the default stall watchdog limit.
package vx_sched_wctl_checker_pkg;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_INACTIVE      = 3'd1,
    ERR_EMPTY_MASK    = 3'd2,
    ERR_STALL_TIMEOUT = 3'd3,
    ERR_WSPAWN_MULTI  = 3'd4,
    ERR_POST_DONE     = 3'd5
  } sched_chk_err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_chk_state_e;

  localparam int DEF_STALL_TIMEOUT = 256;

endpackage

// File: rtl/vx_sched_wctl_checker_stall_watchdog.sv
// Per-warp stall watchdog: counts active stalled cycles, pulses once when the
// count reaches STALL_TIMEOUT, then saturates until the stall drops.
module vx_stall_watchdog
  import vx_sched_wctl_checker_pkg::*;
#(
  parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic stalled,
  input  logic active,
  output logic timeout_pulse
);

  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // An inactive or unchecked warp holds its count; only a stall drop clears it.
  always_comb begin
    cnt_d         = cnt_q;
    timeout_pulse = 1'b0;
    if (!stalled) begin
      cnt_d = '0;
    end else if (active && enable && (cnt_q != LIMIT)) begin
      cnt_d         = cnt_q + CW'(1);
      timeout_pulse = (cnt_q == LIMIT - CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vx_sched_wctl_checker.sv
// Scheduler protocol checker: kernel FSM, prioritised error reporting and
// saturating event counters. Define VX_SCHED_WCTL_CHK_ASSERT_EN for sim messages.
module vx_sched_wctl_checker
  import vx_sched_wctl_checker_pkg::*;
#(
  parameter int  NUM_WARPS     = 4,
  parameter int  NUM_THREADS   = 4,
  parameter int  STALL_TIMEOUT = DEF_STALL_TIMEOUT,
  parameter int  CNT_W         = 16,
  localparam int NW_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             warp_ctl_valid,
  input  logic                             wspawn_valid,
  input  logic                             join_valid,
  input  logic [NW_WIDTH-1:0]              wid,
  input  logic [NUM_WARPS-1:0]             active_warps,
  input  logic [NUM_WARPS-1:0]             stalled_warps,
  input  logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic                             err_valid,
  output logic [2:0]                       err_code,
  output logic [NW_WIDTH-1:0]              err_wid,
  output logic                             err_any,
  output logic                             kernel_done,
  output logic [CNT_W-1:0]                 wctl_cnt,
  output logic [CNT_W-1:0]                 wspawn_cnt,
  output logic [CNT_W-1:0]                 join_cnt
);

  sched_chk_state_e     state_q, state_d;
  sched_chk_err_e       err_code_q, err_code_d;
  logic                 chk_en, kernel_done_d, kernel_done_q;
  logic                 err_valid_d, err_valid_q, err_any_d, err_any_q;
  logic [NW_WIDTH-1:0]  err_wid_d, err_wid_q, empty_idx, tmo_idx;
  logic [NUM_WARPS-1:0] empty_now, empty_d, empty_q, empty_err, tmo_pulse;
  logic [CNT_W-1:0]     wctl_cnt_d, wctl_cnt_q, wspawn_cnt_d, wspawn_cnt_q;
  logic [CNT_W-1:0]     join_cnt_d, join_cnt_q;
  logic                 any_event, ev_inactive, ev_multi;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|active_warps) state_d = RUN;
      RUN:     if (~|active_warps) state_d = DRAIN;
      DRAIN:   state_d = (|active_warps) ? RUN : DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chk_en        = (state_q == RUN) || (state_q == DRAIN);
    kernel_done_d = (state_q == DRAIN) && ~|active_warps;
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    vx_stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_wd (
      .clk          (clk),
      .reset        (reset),
      .enable       (chk_en),
      .stalled      (stalled_warps[w]),
      .active       (active_warps[w]),
      .timeout_pulse(tmo_pulse[w])
    );
    assign empty_now[w] = active_warps[w] &&
                          (thread_masks[w*NUM_THREADS +: NUM_THREADS] == '0);
  end

  assign any_event   = warp_ctl_valid | wspawn_valid | join_valid;
  assign ev_inactive = (warp_ctl_valid | join_valid) & ~active_warps[wid];
  // More than one bit set in the active mask.
  assign ev_multi    = wspawn_valid &
                       ((active_warps & (active_warps - NUM_WARPS'(1))) != '0);
  assign empty_err   = empty_now & empty_q;

  // Only the lowest error code is reported, lowest offending warp first.
  always_comb begin
    err_valid_d = 1'b0;
    err_code_d  = ERR_NONE;
    err_wid_d   = '0;
    empty_idx   = '0;
    tmo_idx     = '0;
    empty_d     = empty_now;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (empty_err[w]) empty_idx = NW_WIDTH'(w);
      if (tmo_pulse[w]) tmo_idx   = NW_WIDTH'(w);
    end
    if (chk_en) begin
      if (ev_inactive) begin
        err_valid_d = 1'b1; err_code_d = ERR_INACTIVE;      err_wid_d = wid;
      end else if (|empty_err) begin
        err_valid_d = 1'b1; err_code_d = ERR_EMPTY_MASK;    err_wid_d = empty_idx;
      end else if (|tmo_pulse) begin
        err_valid_d = 1'b1; err_code_d = ERR_STALL_TIMEOUT; err_wid_d = tmo_idx;
      end else if (ev_multi) begin
        err_valid_d = 1'b1; err_code_d = ERR_WSPAWN_MULTI;  err_wid_d = wid;
      end
    end else if ((state_q == DONE) && any_event) begin
      err_valid_d = 1'b1; err_code_d = ERR_POST_DONE; err_wid_d = wid;
    end
    err_any_d    = err_any_q | err_valid_d;
    wctl_cnt_d   = sat_inc(wctl_cnt_q, warp_ctl_valid);
    wspawn_cnt_d = sat_inc(wspawn_cnt_q, wspawn_valid);
    join_cnt_d   = sat_inc(join_cnt_q, join_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_wid_q     <= '0;
      err_any_q     <= 1'b0;
      kernel_done_q <= 1'b0;
      empty_q       <= '0;
      wctl_cnt_q    <= '0;
      wspawn_cnt_q  <= '0;
      join_cnt_q    <= '0;
    end else begin
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
      err_wid_q     <= err_wid_d;
      err_any_q     <= err_any_d;
      kernel_done_q <= kernel_done_d;
      empty_q       <= empty_d;
      wctl_cnt_q    <= wctl_cnt_d;
      wspawn_cnt_q  <= wspawn_cnt_d;
      join_cnt_q    <= join_cnt_d;
    end
  end

  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign err_wid     = err_wid_q;
  assign err_any     = err_any_q;
  assign kernel_done = kernel_done_q;
  assign wctl_cnt    = wctl_cnt_q;
  assign wspawn_cnt  = wspawn_cnt_q;
  assign join_cnt    = join_cnt_q;

`ifdef VX_SCHED_WCTL_CHK_ASSERT_EN
  logic [31:0] cycle_q;
  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
    if (!reset && err_valid_q)
      $error("sched checker: code=%0d wid=%0d cycle=%0d", err_code_q, err_wid_q, cycle_q);
    if (!reset && kernel_done_q)
      $display("sched checker: kernel done wctl=%0d wspawn=%0d join=%0d",
               wctl_cnt_q, wspawn_cnt_q, join_cnt_q);
  end
`else
`endif

endmodule

// File: doc/vx_sched_wctl_checker.md
Name: vx_sched_wctl_checker

Overview:
- Bench-side sequential checker that sits directly downstream of the scheduler TB interface.
- Consumes the warp-control, wspawn and join events plus the active/stalled/thread-mask state that the interface samples.
- Flags scheduler protocol violations, counts events and detects end of kernel.
- Synthesizable subset only, so it can also be bound into emulation builds.

Parameters:
- NUM_WARPS, 4, number of warps; equals `NUM_WARPS in the bench.
- NUM_THREADS, 4, threads per warp; equals `NUM_THREADS.
- STALL_TIMEOUT, 256, maximum cycles a warp may stay stalled before an error is raised.
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- warp_ctl_valid  in  1  warp-control (TMC/pred) commit.
- wspawn_valid  in  1  wspawn commit.
- join_valid  in  1  join commit.
- wid  in  NW_WIDTH  warp id of the current wctl/join event.
- active_warps  in  NUM_WARPS  scheduler active mask.
- stalled_warps  in  NUM_WARPS  scheduler stall mask.
- thread_masks  in  NUM_WARPS*NUM_THREADS  per-warp thread masks.
- err_valid  out  1  one-cycle pulse when an error is detected.
- err_code  out  3  error code; valid with err_valid.
- err_wid  out  NW_WIDTH  offending warp; valid with err_valid.
- err_any  out  1  sticky OR of all errors since reset.
- kernel_done  out  1  one-cycle pulse when all warps retire.
- wctl_cnt, wspawn_cnt, join_cnt  out  CNT_W  saturating event counts.

Behaviour:
- Reset: all outputs 0, counters 0, watchdogs 0, FSM IDLE. Reset asserted mid-run discards every pending state on the same edge, with no err or done pulse.
- FSM:
  - IDLE -> RUN when active_warps != 0.
  - RUN -> DRAIN when active_warps == 0.
  - DRAIN -> DONE after 1 cycle if active_warps is still 0. kernel_done pulses on DRAIN->DONE.
  - DRAIN -> RUN if any warp reactivates.
  - DONE is terminal until reset. Any event while in DONE raises ERR_POST_DONE(5), with err_wid = wid.
- Checks are evaluated only in RUN/DRAIN, on registered inputs; err_valid appears 1 cycle after the offending sample.
  - ERR_INACTIVE(1): warp_ctl_valid or join_valid while active_warps[wid] == 0.
  - ERR_EMPTY_MASK(2): active_warps[w] == 1 and thread_masks[w] == 0 for 2 consecutive cycles.
  - ERR_STALL_TIMEOUT(3): the per-warp counter reaches STALL_TIMEOUT.
    - The counter increments while stalled_warps[w] is set and clears when it drops.
    - It saturates after flagging and flags only once per stall episode.
  - ERR_WSPAWN_MULTI(4): wspawn_valid while more than 1 warp is active. A wspawn issued from a single active warp is legal.
- Simultaneous errors: only the lowest code is reported, with the lowest warp index among offenders. The others are dropped from err_valid but still set err_any.
- Counters: increment on the matching valid and saturate at 2^CNT_W-1 with no wrap. Simultaneous valids each increment their own counter.
- Stall with warp inactive: the watchdog holds its value and does not count.

Optional Feature:
- Macro: VX_SCHED_WCTL_CHK_ASSERT_EN.
- When defined: every err_valid also fires an $error naming the code, wid and cycle. kernel_done prints the three counters via $display.
- When undefined: no simulation messages; the port behaviour is identical.

Decomposition:
- VX_tb_common_pkg gains:
  - the sched_chk_err_e enum with codes 0..5 (0 = NONE);
  - the sched_chk_state_e enum {IDLE, RUN, DRAIN, DONE};
  - the STALL_TIMEOUT default constant.
- One sub-module, vx_stall_watchdog: one per warp via generate. Ports are clk, reset, enable, stalled, active and timeout_pulse.

Test Plan:
- Normal kernel: active 0001; wspawn from warp0 -> active 1111; then all warps retire -> wspawn_cnt=1, kernel_done pulses once 2 cycles after active=0, err_any=0.
- warp_ctl_valid with wid=2 while active=0011 -> err_valid next cycle, err_code=1, err_wid=2.
- Warp1 stalled for 256 cycles -> exactly one err_code=3, err_wid=1 pulse; stall drops then re-rises -> counter restarts from 0.
- Same cycle: join on inactive warp3 plus warp0 thread mask at 0 for 2 cycles -> err_code=1, err_wid=3 reported; err_any=1.
- 70000 warp_ctl events with CNT_W=16 -> wctl_cnt holds 65535.
- Reset asserted during DRAIN -> no kernel_done; all outputs 0 next cycle; FSM in IDLE.
